// File: rtl/roce_drop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : roce_drop_pkg                                                   |
// | Brief    : Mode encodings, default LFSR taps and LFSR step function.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package roce_drop_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF      = 2'd0;
  localparam mode_t MODE_PERIODIC = 2'd1;
  localparam mode_t MODE_RANDOM   = 2'd2;
  localparam mode_t MODE_ONESHOT  = 2'd3;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois step: feedback is the bit shifted out of bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps);
    logic [31:0] shifted;
    shifted = {1'b0, state[31:1]};
    return state[0] ? (shifted ^ taps) : shifted;
  endfunction

endpackage : roce_drop_pkg
`default_nettype wire

// File: rtl/roce_drop_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : roce_drop_if                                                    |
// | Brief    : Dropper <-> scheduler handshake observation and decision bus.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface roce_drop_if;

  logic        bth_fire;
  logic [23:0] bth_psn;
  logic        pay_last_fire;
  logic        bth_stall;
  logic        drop_flag;

  modport master (
    output bth_fire,
    output bth_psn,
    output pay_last_fire,
    input  bth_stall,
    input  drop_flag
  );

  modport slave (
    input  bth_fire,
    input  bth_psn,
    input  pay_last_fire,
    output bth_stall,
    output drop_flag
  );

endinterface : roce_drop_if
`default_nettype wire

// File: rtl/roce_drop_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : roce_drop_lfsr                                                  |
// | Brief    : 32-bit Galois LFSR with seed load (load wins over advance).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module roce_drop_lfsr
  import roce_drop_pkg::*;
#(
  parameter logic [31:0] TAPS = DEFAULT_LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // An all-zero state would lock the register, so a zero seed maps to 1.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (adv) begin
      state_d = lfsr_next(state_q, TAPS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 32'd1;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule : roce_drop_lfsr
`default_nettype wire

// File: rtl/roce_drop_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : roce_drop_scheduler                                             |
// | Brief    : Per-packet drop decision, decision queue and drop statistics.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module roce_drop_scheduler
  import roce_drop_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  roce_drop_if.slave           bus,
  input  mode_t                cfg_mode,
  input  logic [15:0]          cfg_period,
  input  logic [31:0]          cfg_threshold,
  input  logic [23:0]          cfg_target_psn,
  input  logic                 cfg_arm,
  input  logic [31:0]          cfg_seed,
  input  logic                 cfg_seed_load,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stat_pkt_count,
  output logic [CNT_WIDTH-1:0] stat_drop_count,
  output logic                 underflow
);

  localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic [15:0]           period_cnt_q, period_cnt_d;
  logic                  armed_q, armed_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, drop_cnt_q;
  logic                  underflow_q;
  logic [31:0]           lfsr_state;
  logic                  full, empty, push, pop, dec;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = bus.pay_last_fire && !empty;
  // A full queue still accepts a BTH when the head retires in the same cycle.
  assign push  = bus.bth_fire && (!full || pop);

  roce_drop_lfsr #(
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (push),
    .load (cfg_seed_load),
    .seed (cfg_seed),
    .q    (lfsr_state)
  );

  always_comb begin
    dec = 1'b0;
    case (cfg_mode)
      MODE_PERIODIC: dec = (cfg_period != 16'd0) && (period_cnt_q == cfg_period - 16'd1);
      MODE_RANDOM:   dec = (lfsr_state < cfg_threshold);
      MODE_ONESHOT:  dec = armed_q && (bus.bth_psn == cfg_target_psn);
      default:       dec = 1'b0;
    endcase
  end

  // A counter left beyond a shrunken period restarts at 0 without dropping.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (push && (cfg_mode == MODE_PERIODIC)) begin
      if ((period_cnt_q >= cfg_period) || (period_cnt_q == cfg_period - 16'd1)) begin
        period_cnt_d = 16'd0;
      end else begin
        period_cnt_d = period_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    armed_d = armed_q;
    if (cfg_arm) begin
      armed_d = 1'b1;
    end else if (push && (cfg_mode == MODE_ONESHOT) && dec) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      period_cnt_q <= 16'd0;
      armed_q      <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= dec;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q      <= count_d;
      period_cnt_q <= period_cnt_d;
      armed_q      <= armed_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else if (stat_clear) begin
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      end
      if (push && dec) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
      if (bus.pay_last_fire && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.bth_stall  = full;
  assign bus.drop_flag  = !empty && fifo_q[rd_ptr_q];
  assign stat_pkt_count  = pkt_cnt_q;
  assign stat_drop_count = drop_cnt_q;
  assign underflow       = underflow_q;

endmodule : roce_drop_scheduler
`default_nettype wire

// File: tb/tb_roce_drop_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_roce_drop_scheduler                                          |
// | Brief    : Directed self-checking bench for roce_drop_scheduler.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_roce_drop_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_period;
  logic [31:0] cfg_threshold;
  logic [23:0] cfg_target_psn;
  logic        cfg_arm;
  logic [31:0] cfg_seed;
  logic        cfg_seed_load;
  logic        stat_clear;
  logic [31:0] stat_pkt_count;
  logic [31:0] stat_drop_count;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  roce_drop_if bus ();

  roce_drop_scheduler #(
    .FIFO_DEPTH (4),
    .LFSR_TAPS  (32'h8020_0003),
    .CNT_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .cfg_mode        (cfg_mode),
    .cfg_period      (cfg_period),
    .cfg_threshold   (cfg_threshold),
    .cfg_target_psn  (cfg_target_psn),
    .cfg_arm         (cfg_arm),
    .cfg_seed        (cfg_seed),
    .cfg_seed_load   (cfg_seed_load),
    .stat_clear      (stat_clear),
    .stat_pkt_count  (stat_pkt_count),
    .stat_drop_count (stat_drop_count),
    .underflow       (underflow)
  );

  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    logic [31:0] sh;
    sh = {1'b0, s[31:1]};
    return s[0] ? (sh ^ 32'h8020_0003) : sh;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.bth_fire      = 1'b0;
    bus.bth_psn       = 24'd0;
    bus.pay_last_fire = 1'b0;
    cfg_mode = 2'd0; cfg_period = 16'd0; cfg_threshold = 32'd0; cfg_target_psn = 24'd0;
    cfg_arm = 1'b0; cfg_seed = 32'd0; cfg_seed_load = 1'b0; stat_clear = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.bth_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.bth_stall); end
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL reset_drop_flag: got %b expected 0", bus.drop_flag); end
    checks++; if (stat_pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", stat_pkt_count); end
    checks++; if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", stat_drop_count); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
  endtask

  // Packet i's BTH overlaps packet i-1's tlast; period 4 drops packets 3, 7, 11.
  task automatic test_periodic();
    apply_reset();
    cfg_mode = 2'd1; cfg_period = 16'd4;
    for (int i = 0; i <= 12; i++) begin
      bus.bth_fire = (i < 12); bus.bth_psn = 24'(i); bus.pay_last_fire = (i > 0);
      if (i > 0) begin
        logic e;
        e = (((i - 1) % 4) == 3);
        checks++; if (bus.drop_flag !== e) begin errors++; $display("FAIL periodic_pkt%0d_flag: got %b expected %b", i - 1, bus.drop_flag, e); end
      end
      tick();
    end
    bus.bth_fire = 1'b0; bus.pay_last_fire = 1'b0;
    checks++; if (stat_pkt_count !== 32'd12) begin errors++; $display("FAIL periodic_pkt_count: got %0d expected 12", stat_pkt_count); end
    checks++; if (stat_drop_count !== 32'd3) begin errors++; $display("FAIL periodic_drop_count: got %0d expected 3", stat_drop_count); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL periodic_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic        prev;
    int          mism;
    int          ndrop;
    apply_reset();
    cfg_mode = 2'd2; cfg_threshold = 32'h8000_0000;
    cfg_seed = 32'd1; cfg_seed_load = 1'b1;
    tick();
    cfg_seed_load = 1'b0;
    m = 32'd1; prev = 1'b0; mism = 0; ndrop = 0;
    for (int i = 0; i <= 10000; i++) begin
      bus.bth_fire = (i < 10000); bus.pay_last_fire = (i > 0);
      if ((i > 0) && (bus.drop_flag !== prev)) mism++;
      if (i < 10000) begin
        prev = (m < 32'h8000_0000);
        if (prev) ndrop++;
        m = model_lfsr(m);
      end
      tick();
    end
    bus.bth_fire = 1'b0; bus.pay_last_fire = 1'b0;
    checks++; if (mism != 0) begin errors++; $display("FAIL random_decisions: got %0d mismatching packets expected 0", mism); end
    checks++; if (stat_drop_count !== 32'(ndrop)) begin errors++; $display("FAIL random_drop_count: got %0d expected %0d", stat_drop_count, ndrop); end
    checks++; if ((stat_drop_count < 32'd4700) || (stat_drop_count > 32'd5300)) begin errors++; $display("FAIL random_drop_range: got %0d expected 4700..5300", stat_drop_count); end
    checks++; if (stat_pkt_count !== 32'd10000) begin errors++; $display("FAIL random_pkt_count: got %0d expected 10000", stat_pkt_count); end
    // Zero seed loads as 1: drops with threshold 2, then the next state 0x80200003 does not.
    cfg_seed = 32'd0; cfg_seed_load = 1'b1; cfg_threshold = 32'd2;
    tick();
    cfg_seed_load = 1'b0;
    bus.bth_fire = 1'b1;
    tick();
    bus.pay_last_fire = 1'b1;
    checks++; if (bus.drop_flag !== 1'b1) begin errors++; $display("FAIL random_seed0_first: got %b expected 1", bus.drop_flag); end
    tick();
    bus.bth_fire = 1'b0;
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL random_seed0_second: got %b expected 0", bus.drop_flag); end
    tick();
    bus.pay_last_fire = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [23:0] psns [10];
    psns = '{24'h0E, 24'h0F, 24'h10, 24'h11, 24'h12, 24'h0E, 24'h0F, 24'h10, 24'h11, 24'h12};
    apply_reset();
    cfg_mode = 2'd3; cfg_target_psn = 24'h10;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      bus.bth_fire = (i < 10); bus.bth_psn = (i < 10) ? psns[i] : 24'd0; bus.pay_last_fire = (i > 0);
      if (i > 0) begin
        logic e;
        e = (i - 1 == 2);
        checks++; if (bus.drop_flag !== e) begin errors++; $display("FAIL oneshot_pkt%0d_flag: got %b expected %b", i - 1, bus.drop_flag, e); end
      end
      tick();
    end
    bus.bth_fire = 1'b0; bus.pay_last_fire = 1'b0;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    bus.bth_fire = 1'b1; bus.bth_psn = 24'h10;
    tick();
    bus.bth_fire = 1'b0;
    checks++; if (bus.drop_flag !== 1'b1) begin errors++; $display("FAIL oneshot_rearm_flag: got %b expected 1", bus.drop_flag); end
    bus.pay_last_fire = 1'b1;
    tick();
    bus.pay_last_fire = 1'b0;
    checks++; if (stat_drop_count !== 32'd2) begin errors++; $display("FAIL oneshot_drop_count: got %0d expected 2", stat_drop_count); end
    checks++; if (stat_pkt_count !== 32'd11) begin errors++; $display("FAIL oneshot_pkt_count: got %0d expected 11", stat_pkt_count); end
  endtask

  // Period 2 tags queued packets 0,1,0,1,0 so queue order is visible on drop_flag.
  task automatic test_full_stall();
    logic [3:0] exp_heads;
    exp_heads = 4'b0101;
    apply_reset();
    cfg_mode = 2'd1; cfg_period = 16'd2;
    bus.bth_fire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.bth_fire = 1'b0;
    checks++; if (bus.bth_stall !== 1'b1) begin errors++; $display("FAIL full_stall_after4: got %b expected 1", bus.bth_stall); end
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL full_head_pkt0: got %b expected 0", bus.drop_flag); end
    bus.bth_fire = 1'b1; bus.pay_last_fire = 1'b1;
    tick();
    bus.bth_fire = 1'b0; bus.pay_last_fire = 1'b0;
    checks++; if (bus.bth_stall !== 1'b1) begin errors++; $display("FAIL full_stall_pushpop: got %b expected 1", bus.bth_stall); end
    checks++; if (stat_pkt_count !== 32'd5) begin errors++; $display("FAIL full_pkt_count_pushpop: got %0d expected 5", stat_pkt_count); end
    bus.bth_fire = 1'b1;
    tick();
    bus.bth_fire = 1'b0;
    checks++; if (stat_pkt_count !== 32'd5) begin errors++; $display("FAIL full_ignored_bth: got %0d expected 5", stat_pkt_count); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (bus.drop_flag !== exp_heads[j]) begin errors++; $display("FAIL full_drain_head%0d: got %b expected %b", j, bus.drop_flag, exp_heads[j]); end
      bus.pay_last_fire = 1'b1;
      tick();
      if (j == 0) begin
        checks++; if (bus.bth_stall !== 1'b0) begin errors++; $display("FAIL full_stall_release: got %b expected 0", bus.bth_stall); end
      end
    end
    bus.pay_last_fire = 1'b0;
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL full_empty_flag: got %b expected 0", bus.drop_flag); end
    bus.bth_fire = 1'b1;
    tick();
    bus.bth_fire = 1'b0;
    checks++; if (bus.drop_flag !== 1'b1) begin errors++; $display("FAIL full_next_decision: got %b expected 1", bus.drop_flag); end
    checks++; if (stat_drop_count !== 32'd3) begin errors++; $display("FAIL full_drop_count: got %0d expected 3", stat_drop_count); end
  endtask

  task automatic test_underflow();
    apply_reset();
    cfg_mode = 2'd1; cfg_period = 16'd1;
    bus.bth_fire = 1'b1;
    tick();
    tick();
    bus.bth_fire = 1'b0;
    checks++; if (stat_drop_count !== 32'd2) begin errors++; $display("FAIL uf_pre_drop_count: got %0d expected 2", stat_drop_count); end
    bus.pay_last_fire = 1'b1;
    tick();
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_not_yet: got %b expected 0", underflow); end
    tick();
    bus.pay_last_fire = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL uf_drop_flag: got %b expected 0", bus.drop_flag); end
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
    stat_clear = 1'b1; bus.bth_fire = 1'b1;
    tick();
    stat_clear = 1'b0; bus.bth_fire = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", underflow); end
    checks++; if (stat_pkt_count !== 32'd0) begin errors++; $display("FAIL uf_clear_pkt_count: got %0d expected 0", stat_pkt_count); end
    checks++; if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL uf_clear_drop_count: got %0d expected 0", stat_drop_count); end
    checks++; if (bus.drop_flag !== 1'b1) begin errors++; $display("FAIL uf_clear_push_flag: got %b expected 1", bus.drop_flag); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    cfg_mode = 2'd1; cfg_period = 16'd3;
    bus.bth_fire = 1'b1;
    tick();
    tick();
    bus.bth_fire = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.bth_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", bus.bth_stall); end
    checks++; if (bus.drop_flag !== 1'b0) begin errors++; $display("FAIL midrst_drop_flag: got %b expected 0", bus.drop_flag); end
    checks++; if (stat_pkt_count !== 32'd0) begin errors++; $display("FAIL midrst_pkt_count: got %0d expected 0", stat_pkt_count); end
    checks++; if (stat_drop_count !== 32'd0) begin errors++; $display("FAIL midrst_drop_count: got %0d expected 0", stat_drop_count); end
    rst = 1'b0;
    tick();
    bus.pay_last_fire = 1'b1;
    tick();
    bus.pay_last_fire = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL midrst_underflow: got %b expected 1", underflow); end
    for (int i = 0; i <= 3; i++) begin
      bus.bth_fire = (i < 3); bus.pay_last_fire = (i > 0);
      if (i > 0) begin
        logic e;
        e = (i - 1 == 2);
        checks++; if (bus.drop_flag !== e) begin errors++; $display("FAIL midrst_pkt%0d_flag: got %b expected %b", i - 1, bus.drop_flag, e); end
      end
      tick();
    end
    bus.bth_fire = 1'b0; bus.pay_last_fire = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_random();
    test_oneshot();
    test_full_stall();
    test_underflow();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_roce_drop_scheduler
`default_nettype wire
